// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle PC/IR sequencer driving instruction_memory and selecting next PC after execute.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          IMEM_DEPTH  = 256,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic        halted,
    output logic        pc_fault,
    output logic [31:0] retired
);
    typedef enum logic [1:0] {ISSUE, CAPTURE, EXEC, HALT} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, ir_n, retired_n, pc_plus1, next_pc;
    logic        fault_n, out_of_range;
    assign pc_plus1     = pc + 32'd1;
    assign out_of_range = pc >= 32'(IMEM_DEPTH);
    assign next_pc      = jump_reg     ? reg_target :
                          jump         ? {pc_plus1[31:26], ir[25:0]} :
                          branch_taken ? pc_plus1 + {{16{ir[15]}}, ir[15:0]} :
                                         pc_plus1;
    assign imem_pc  = pc;
    assign ir_valid = state == EXEC;
    assign halted   = state == HALT;
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        retired_n = retired;
        fault_n   = pc_fault;
        case (state)
            ISSUE: begin
                state_n = out_of_range ? HALT : CAPTURE;
                fault_n = out_of_range;
            end
            CAPTURE: begin
                ir_n    = imem_instr;
                state_n = (imem_instr[31:26] == HALT_OPCODE) ? HALT : EXEC;
            end
            EXEC: if (exec_done) begin
                retired_n = retired + 32'd1;
                pc_n      = next_pc;
                state_n   = ISSUE;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ISSUE;
            pc       <= RESET_PC;
            ir       <= '0;
            retired  <= '0;
            pc_fault <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            retired  <= retired_n;
            pc_fault <= fault_n;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a registered instruction memory model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_pc, imem_instr, ir, reg_target, retired;
    logic        ir_valid, exec_done, branch_taken, jump, jump_reg, halted, pc_fault;
    logic [31:0] mem [0:255];
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;
    fetch_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_ret   = 0;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done), .branch_taken(branch_taken),
        .jump(jump), .jump_reg(jump_reg), .reg_target(reg_target),
        .halted(halted), .pc_fault(pc_fault), .retired(retired)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        imem_instr <= (imem_pc < 32'd256) ? mem[imem_pc[7:0]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back('{pc, mem[pc[7:0]]});
    endtask

    task automatic clear_ctrl();
        exec_done = 0; branch_taken = 0; jump = 0; jump_reg = 0; reg_target = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_pc", imem_pc, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, pc_fault}, 32'd0);
        check("rst_retired", retired, 32'd0);
        exp_q.delete();
        n_ret = 0;
        clear_ctrl();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_exec(output int k);
        k = 0;
        while (!ir_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("exec_reached", {31'd0, ir_valid}, 32'd1);
    endtask

    task automatic step(input logic br, input logic j, input logic jr,
                        input logic [31:0] tgt, input int stall);
        fetch_t e;
        int k;
        wait_exec(k);
        check("latency", k, 32'd2);
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
            e = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        end else e = exp_q.pop_front();
        check("fetch_pc", imem_pc, e.pc);
        check("fetch_ir", ir, e.instr);
        for (int s = 0; s < stall; s++) begin
            branch_taken = 1'($urandom);
            jump         = 1'($urandom);
            jump_reg     = 1'($urandom);
            reg_target   = $urandom;
            @(negedge clk);
            check("stall_ir", ir, e.instr);
            check("stall_pc", imem_pc, e.pc);
            check("stall_valid", {31'd0, ir_valid}, 32'd1);
        end
        branch_taken = br; jump = j; jump_reg = jr; reg_target = tgt; exec_done = 1;
        @(negedge clk);
        clear_ctrl();
        n_ret++;
        check("valid_drop", {31'd0, ir_valid}, 32'd0);
        check("retired", retired, 32'(n_ret));
    endtask

    initial begin
        int k;
        clear_ctrl();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[0]  = 32'h8C01_0020;
        mem[1]  = 32'h8C02_0020;
        mem[2]  = 32'h0800_0010;
        mem[3]  = 32'h0000_0003;
        mem[4]  = 32'h1000_FFFD;
        mem[16] = 32'h0000_0020;
        mem[7]  = 32'h0000_ABCD;
        do_reset();
        expect_fetch(0); step(0, 0, 0, 0, 0);
        expect_fetch(1); step(0, 0, 0, 0, 0);
        check("retired_two", retired, 32'd2);
        expect_fetch(2); step(0, 0, 0, 0, 0);
        expect_fetch(3); step(0, 0, 0, 0, 10);
        expect_fetch(4); step(1, 0, 0, 0, 0);
        expect_fetch(2); step(0, 1, 0, 0, 0);
        expect_fetch(32'h10); step(0, 1, 1, 32'd7, 0);
        expect_fetch(7); step(0, 0, 1, 32'd256, 0);
        check("oor_pc", imem_pc, 32'd256);
        check("oor_not_yet", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check("oor_halted", {31'd0, halted}, 32'd1);
        check("oor_fault", {31'd0, pc_fault}, 32'd1);
        repeat (3) begin
            exec_done = 1;
            @(negedge clk);
            check("oor_ir_hold", ir, 32'h0000_ABCD);
            check("oor_valid", {31'd0, ir_valid}, 32'd0);
            check("oor_retired", retired, 32'd8);
        end
        clear_ctrl();

        mem[0] = 32'h0000_0001; mem[1] = 32'h0000_0002; mem[2] = 32'h0000_0003;
        mem[3] = 32'hFC00_0123;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_fetch(32'(i));
            step(0, 0, 0, 0, 0);
        end
        k = 0;
        while (!halted && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("halt_seen", {31'd0, halted}, 32'd1);
        check("halt_fault", {31'd0, pc_fault}, 32'd0);
        check("halt_valid", {31'd0, ir_valid}, 32'd0);
        check("halt_ir", ir, 32'hFC00_0123);
        repeat (3) begin
            exec_done = 1; jump_reg = 1; reg_target = 32'd5;
            @(negedge clk);
            clear_ctrl();
            @(negedge clk);
            check("halt_retired", retired, 32'd3);
            check("halt_pc", imem_pc, 32'd3);
            check("halt_hold", {31'd0, halted}, 32'd1);
        end

        mem[0] = 32'h8C01_0020; mem[1] = 32'h8C02_0020;
        do_reset();
        expect_fetch(0); step(0, 0, 0, 0, 0);
        wait_exec(k);
        check("mid_pc", imem_pc, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_pc", imem_pc, 32'd0);
        check("async_ir", ir, 32'd0);
        check("async_valid", {31'd0, ir_valid}, 32'd0);
        check("async_retired", retired, 32'd0);
        check("async_halted", {31'd0, halted}, 32'd0);
        exp_q.delete();
        n_ret = 0;
        @(negedge clk);
        reset = 1'b0;
        expect_fetch(0); step(0, 0, 0, 0, 0);
        expect_fetch(1); step(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
